// File: rtl/truth_table_sweeper_pkg.sv
// sweep_pkg: FSM state encoding and settle-counter width helper for truth_table_sweeper
package sweep_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CHECK, ST_DONE} state_t;
  function automatic int settle_w(int s);
    return $clog2(s + 1);
  endfunction
endpackage

// File: rtl/truth_table_sweeper_mux_tree.sv
// mux_tree: 2^N:1 bit selector built from 2:1 stages; y = tbl[sel]
//   tbl in 2^N, sel in N (sel[N-1] picks at the root), y out 1
module mux_tree #(
  parameter int N = 4
) (
  input  logic [2**N-1:0] tbl,
  input  logic [N-1:0]    sel,
  output logic            y
);
  for (genvar d = 0; d <= N; d++) begin : lvl
    logic [2**d-1:0] v;
    if (d == N) begin : g_leaf
      assign v = tbl;
    end else begin : g_node
      for (genvar j = 0; j < 2**d; j++) begin : g_mux
        assign v[j] = sel[N-1-d] ? lvl[d+1].v[2*j+1] : lvl[d+1].v[2*j];
      end
    end
  end
  assign y = lvl[0].v[0];
endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: walks all 2^N vectors, checks dut_y against a latched truth table
//   in : clk, rst (async, active-high), start, truth_table[2^N], dut_y
//   out: vec_out[N], busy, done, pass, err_count[N+1], first_fail_vec[N], first_fail_vld
//   FIRST_FAIL_EN: when defined, captures the first mismatching vector; otherwise those outputs are 0
module truth_table_sweeper import sweep_pkg::*; #(
  parameter int N      = 4,
  parameter int SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2**N-1:0] truth_table,
  input  logic            dut_y,
  output logic [N-1:0]    vec_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N:0]      err_count,
  output logic [N-1:0]    first_fail_vec,
  output logic            first_fail_vld
);
  localparam int SW = settle_w(SETTLE);
  state_t          state_q, state_d;
  logic [N-1:0]    vec_q, vec_d;
  logic [SW-1:0]   scnt_q, scnt_d;
  logic [N:0]      err_q, err_d;
  logic [2**N-1:0] tbl_q, tbl_d;
  logic            busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic            exp_y, mis, go;
  mux_tree #(.N(N)) u_mux (.tbl(tbl_q), .sel(vec_q), .y(exp_y));
  assign go  = state_q == ST_IDLE && start;
  assign mis = state_q == ST_CHECK && dut_y != exp_y;
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    scnt_d  = scnt_q;
    err_d   = err_q;
    tbl_d   = tbl_q;
    busy_d  = busy_q;
    pass_d  = pass_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_SETTLE;
        tbl_d   = truth_table;
        err_d   = '0;
        vec_d   = '0;
        scnt_d  = '0;
        pass_d  = 1'b0;
        busy_d  = 1'b1;
      end
      ST_SETTLE: begin
        scnt_d  = scnt_q + 1'b1;
        state_d = scnt_q == SW'(SETTLE - 1) ? ST_CHECK : ST_SETTLE;
      end
      ST_CHECK: begin
        err_d   = err_q + {{N{1'b0}}, mis};
        state_d = &vec_q ? ST_DONE : ST_SETTLE;
        vec_d   = &vec_q ? vec_q : vec_q + 1'b1;
        scnt_d  = '0;
      end
      ST_DONE: begin
        done_d  = 1'b1;
        pass_d  = err_q == '0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      scnt_q  <= '0;
      err_q   <= '0;
      tbl_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      scnt_q  <= scnt_d;
      err_q   <= err_d;
      tbl_q   <= tbl_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end
  assign vec_out   = vec_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
`ifdef FIRST_FAIL_EN
  logic [N-1:0] ffv_q, ffv_d;
  logic         ffl_q, ffl_d;
  always_comb begin
    ffv_d = go ? '0 : (mis && !ffl_q) ? vec_q : ffv_q;
    ffl_d = go ? 1'b0 : ffl_q | mis;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ffv_q <= '0;
      ffl_q <= 1'b0;
    end else begin
      ffv_q <= ffv_d;
      ffl_q <= ffl_d;
    end
  end
  assign first_fail_vec = ffv_q;
  assign first_fail_vld = ffl_q;
`else
  assign first_fail_vec = '0;
  assign first_fail_vld = 1'b0;
`endif
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: table-driven and randomized checks of truth_table_sweeper
module tb_truth_table_sweeper;
`ifdef FIRST_FAIL_EN
  localparam bit FF = 1'b1;
`else
  localparam bit FF = 1'b0;
`endif
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, start2 = 1'b0;
  logic [15:0] truth_table = '0, dut_fn = '0;
  logic [3:0]  tbl2 = '0;
  logic        dut_y, done, busy, pass, ffl, dut_y2, done2, busy2, pass2, ffl2;
  logic [3:0]  vec_out, ffv;
  logic [4:0]  err_count;
  logic [1:0]  vec2, ffv2;
  logic [2:0]  err2;
  int          checks = 0, errors = 0;
  assign dut_y  = dut_fn[vec_out];
  assign dut_y2 = &vec2;
  always #5 clk = ~clk;
  truth_table_sweeper #(.N(4), .SETTLE(2)) dut (
    .clk(clk), .rst(rst), .start(start), .truth_table(truth_table), .dut_y(dut_y),
    .vec_out(vec_out), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_fail_vec(ffv), .first_fail_vld(ffl));
  truth_table_sweeper #(.N(2), .SETTLE(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .truth_table(tbl2), .dut_y(dut_y2),
    .vec_out(vec2), .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .first_fail_vec(ffv2), .first_fail_vld(ffl2));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  // Reference: mismatches are exactly the bits where the DUT function differs from the table.
  task automatic model(input logic [15:0] tbl, input logic [15:0] fn, output int err, output logic [3:0] first);
    logic [15:0] diff;
    diff  = tbl ^ fn;
    err   = $countones(diff);
    first = '0;
    for (int i = 15; i >= 0; i--) if (diff[i]) first = 4'(i);
  endtask
  // mode 0: plain; 1: extra start pulses mid-sweep; 2: truth_table changed mid-sweep
  task automatic sweep(input string nm, input logic [15:0] tbl, input logic [15:0] fn,
                       input int exp_err, input logic [3:0] exp_ffv, input int mode);
    int lat;
    @(negedge clk);
    truth_table = tbl;
    dut_fn      = fn;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    chk({nm, " busy"}, busy, 1);
    while (!done && lat < 200) begin
      if (mode == 1 && (lat == 5 || lat == 20)) start = 1'b1;
      if (mode == 2 && lat == 10) truth_table = ~tbl;
      @(negedge clk);
      start = 1'b0;
      lat++;
    end
    chk({nm, " latency"}, lat, 49);
    chk({nm, " err_count"}, err_count, exp_err);
    chk({nm, " pass"}, pass, exp_err == 0);
    chk({nm, " ffv"}, ffv, FF ? exp_ffv : 4'd0);
    chk({nm, " ffl"}, ffl, FF && exp_err != 0);
    chk({nm, " vec_hold"}, vec_out, 15);
    @(negedge clk);
    chk({nm, " done_pulse"}, {done, busy}, 0);
    chk({nm, " err_hold"}, {err_count, pass}, {5'(exp_err), exp_err == 0});
  endtask
  typedef struct {
    logic [15:0] tbl;
    logic [15:0] fn;
    int          err;
    logic [3:0]  ffv;
  } vec_t;
  vec_t vt[6];
  initial begin
    int          e, lat;
    logic [3:0]  f;
    logic [15:0] t, fn;
    vt[0] = '{16'hC080, 16'hC080, 0, 4'd0};
    vt[1] = '{16'hC080, 16'h0000, 3, 4'd7};
    vt[2] = '{16'hFFFF, 16'hFFFF, 0, 4'd0};
    vt[3] = '{16'h0000, 16'hFFFF, 16, 4'd0};
    vt[4] = '{16'h8000, 16'h0000, 1, 4'd15};
    vt[5] = '{16'h0001, 16'h0000, 1, 4'd0};
    repeat (2) @(negedge clk);
    chk("reset outputs", {vec_out, busy, done, pass, err_count, ffv, ffl}, 0);
    chk("reset outputs n2", {vec2, busy2, done2, pass2, err2, ffv2, ffl2}, 0);
    rst = 1'b0;
    foreach (vt[i]) sweep($sformatf("vec%0d", i), vt[i].tbl, vt[i].fn, vt[i].err, vt[i].ffv, 0);
    sweep("restart_ignored", 16'hC080, 16'h0000, 3, 4'd7, 1);
    sweep("tbl_change", 16'hC080, 16'hC080, 0, 4'd0, 2);
    for (int k = 0; k < 8; k++) begin
      t  = 16'($urandom);
      fn = t ^ 16'($urandom & $urandom & $urandom);
      model(t, fn, e, f);
      sweep($sformatf("rand%0d", k), t, fn, e, f, k % 3);
    end
    sweep("pre_reset", 16'hC080, 16'hC080, 0, 4'd0, 0);
    @(negedge clk);
    truth_table = 16'hFFFF;
    dut_fn      = 16'h0000;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (16) @(negedge clk);
    chk("pre_reset err", err_count != 0, 1);
    rst = 1'b1;
    start = 1'b1;
    #1;
    chk("mid reset outputs", {vec_out, busy, done, pass, err_count, ffv, ffl}, 0);
    @(negedge clk);
    chk("start during reset", {busy, vec_out}, 0);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("idle after reset", busy, 0);
    sweep("post_reset", 16'hC080, 16'h0000, 3, 4'd7, 0);
    tbl2 = 4'b1000;
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      lat    = 0;
      while (!done2 && lat < 50) begin
        @(negedge clk);
        lat++;
      end
      chk("n2 latency", lat, 9);
      chk("n2 err", err2, r == 0 ? 0 : 2);
      chk("n2 pass", pass2, r == 0);
      chk("n2 vec_hold", vec2, 3);
      tbl2 = 4'b0001;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
